// File: rtl/spike_io_pkg.sv
// Shared types and constants for the spike rate meter.
package spike_io_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned         PPS_W   = 32;
  localparam logic [PPS_W-1:0]    PPS_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/spike_edge_counter.sv
// Rising-edge detector feeding a saturating per-window spike counter.
module spike_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             clear,
  input  logic             terminal,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             edge_det;

  // count/sat include an edge in the current cycle so the terminal cycle's edge is latched
  always_comb begin
    prev_d   = spike_in;
    edge_det = spike_in & ~prev_q;
    count    = cnt_q;
    sat      = sat_q;
    if (!clear && edge_det) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        sat = 1'b1;
      end else begin
        count = cnt_q + 1'b1;
      end
    end
    cnt_d = count;
    sat_d = sat;
    if (clear || terminal) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

endmodule

// File: rtl/spike_rate_meter.sv
// Two-channel spike rate meter: gated window counts latched, scaled to pps and saturated.
module spike_rate_meter
  import spike_io_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter logic [31:0] PPS_SCALE     = 32'd1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        test_clk,
  input  logic        reset1,
  input  logic        enable,
  input  logic        Ia_spike,
  input  logic        II_spike,
  output logic [31:0] Ia_pps,
  output logic [31:0] II_pps,
  output logic        rate_valid,
  output logic [1:0]  rate_sat
);

  localparam int unsigned      WIN_W    = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam int unsigned      PROD_W   = CNT_W + PPS_W;

  function automatic logic prod_ovf(input logic [PROD_W-1:0] p);
    return |p[PROD_W-1:PPS_W];
  endfunction

  function automatic logic [PPS_W-1:0] sat_pps(input logic [PROD_W-1:0] p);
    return prod_ovf(p) ? PPS_MAX : p[PPS_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   hold_ia_q, hold_ia_d, hold_ii_q, hold_ii_d;
  logic [1:0]         hold_sat_q, hold_sat_d;
  logic               latch_q, latch_d;
  logic [PPS_W-1:0]   ia_pps_q, ia_pps_d, ii_pps_q, ii_pps_d;
  logic               rate_valid_q, rate_valid_d;
  logic [1:0]         rate_sat_q, rate_sat_d;
  logic               count_en, clear, terminal;
  logic [CNT_W-1:0]   ia_count, ii_count;
  logic               ia_sat, ii_sat;
  logic [PROD_W-1:0]  ia_prod, ii_prod;

  spike_edge_counter #(.CNT_W(CNT_W)) u_ia (
    .clk      (test_clk),
    .rst      (reset1),
    .spike_in (Ia_spike),
    .clear    (clear),
    .terminal (terminal),
    .count    (ia_count),
    .sat      (ia_sat)
  );

  spike_edge_counter #(.CNT_W(CNT_W)) u_ii (
    .clk      (test_clk),
    .rst      (reset1),
    .spike_in (II_spike),
    .clear    (clear),
    .terminal (terminal),
    .count    (ii_count),
    .sat      (ii_sat)
  );

  // Dropping enable aborts the window in the same cycle, including the terminal one
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    count_en = (state_q == RUN) && enable;
    clear    = !count_en;
    terminal = count_en && (win_q == WIN_LAST);
    win_d    = (count_en && !terminal) ? win_q + 1'b1 : '0;

    hold_ia_d  = hold_ia_q;
    hold_ii_d  = hold_ii_q;
    hold_sat_d = hold_sat_q;
    if (terminal) begin
      hold_ia_d  = ia_count;
      hold_ii_d  = ii_count;
      hold_sat_d = {ii_sat, ia_sat};
    end
    latch_d = terminal;

    // A latch made before an abort still runs to completion here
    ia_prod      = PROD_W'(hold_ia_q) * PROD_W'(PPS_SCALE);
    ii_prod      = PROD_W'(hold_ii_q) * PROD_W'(PPS_SCALE);
    ia_pps_d     = ia_pps_q;
    ii_pps_d     = ii_pps_q;
    rate_sat_d   = rate_sat_q;
    rate_valid_d = latch_q;
    if (latch_q) begin
      ia_pps_d   = sat_pps(ia_prod);
      ii_pps_d   = sat_pps(ii_prod);
      rate_sat_d = hold_sat_q | {prod_ovf(ii_prod), prod_ovf(ia_prod)};
    end
  end

  always_ff @(posedge test_clk) begin
    if (reset1) begin
      state_q      <= IDLE;
      win_q        <= '0;
      hold_ia_q    <= '0;
      hold_ii_q    <= '0;
      hold_sat_q   <= '0;
      latch_q      <= 1'b0;
      ia_pps_q     <= '0;
      ii_pps_q     <= '0;
      rate_valid_q <= 1'b0;
      rate_sat_q   <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      hold_ia_q    <= hold_ia_d;
      hold_ii_q    <= hold_ii_d;
      hold_sat_q   <= hold_sat_d;
      latch_q      <= latch_d;
      ia_pps_q     <= ia_pps_d;
      ii_pps_q     <= ii_pps_d;
      rate_valid_q <= rate_valid_d;
      rate_sat_q   <= rate_sat_d;
    end
  end

  assign Ia_pps     = ia_pps_q;
  assign II_pps     = ii_pps_q;
  assign rate_valid = rate_valid_q;
  assign rate_sat   = rate_sat_q;

endmodule

// File: tb/tb_spike_rate_meter.sv
// Directed bench: main instance plus a 4-bit-counter and a huge-scale instance on shared stimulus.
module tb_spike_rate_meter;

  logic        clk = 1'b0;
  logic        reset1, enable, Ia, II;
  logic [31:0] ia_m, ii_m, ia_c4, ii_c4, ia_bg, ii_bg;
  logic        rv_m, rv_c4, rv_bg;
  logic [1:0]  sat_m, sat_c4, sat_bg;

  int          n_asrt = 0;
  int          n_fail = 0;
  logic [31:0] e_ia   = '0;
  logic [31:0] e_ii   = '0;
  logic [1:0]  e_sat  = '0;

  always #5 clk = ~clk;

  spike_rate_meter #(.WINDOW_CYCLES(100), .PPS_SCALE(32'd10), .CNT_W(16)) u_main (
    .test_clk(clk), .reset1(reset1), .enable(enable), .Ia_spike(Ia), .II_spike(II),
    .Ia_pps(ia_m), .II_pps(ii_m), .rate_valid(rv_m), .rate_sat(sat_m));

  spike_rate_meter #(.WINDOW_CYCLES(100), .PPS_SCALE(32'd10), .CNT_W(4)) u_c4 (
    .test_clk(clk), .reset1(reset1), .enable(enable), .Ia_spike(Ia), .II_spike(II),
    .Ia_pps(ia_c4), .II_pps(ii_c4), .rate_valid(rv_c4), .rate_sat(sat_c4));

  spike_rate_meter #(.WINDOW_CYCLES(100), .PPS_SCALE(32'h4000_0000), .CNT_W(16)) u_big (
    .test_clk(clk), .reset1(reset1), .enable(enable), .Ia_spike(Ia), .II_spike(II),
    .Ia_pps(ia_bg), .II_pps(ii_bg), .rate_valid(rv_bg), .rate_sat(sat_bg));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {sat, pps} for a window that saw cnt rising edges
  function automatic logic [32:0] model(input int cnt, input int cw, input logic [31:0] scale);
    longint unsigned mx, c, p;
    logic s;
    mx = (64'd1 << cw) - 64'd1;
    c  = longint'(cnt);
    s  = (c > mx);
    if (s) c = mx;
    p = c * {32'd0, scale};
    if (p > 64'hFFFF_FFFF) return {1'b1, 32'hFFFF_FFFF};
    return {s, p[31:0]};
  endfunction

  task automatic check_main(input string nm, input int c, input logic ev);
    check($sformatf("%s.%0d valid", nm, c), {31'd0, rv_m}, {31'd0, ev});
    check($sformatf("%s.%0d Ia_pps", nm, c), ia_m, e_ia);
    check($sformatf("%s.%0d II_pps", nm, c), ii_m, e_ii);
    check($sformatf("%s.%0d sat", nm, c), {30'd0, sat_m}, {30'd0, e_sat});
  endtask

  task automatic check_aux(input string nm, input int p_ia, input int p_ii);
    logic [32:0] ra, rb;
    ra = model(p_ia, 4, 32'd10);
    rb = model(p_ii, 4, 32'd10);
    check({nm, " c4 valid"}, {31'd0, rv_c4}, 32'd1);
    check({nm, " c4 Ia_pps"}, ia_c4, ra[31:0]);
    check({nm, " c4 II_pps"}, ii_c4, rb[31:0]);
    check({nm, " c4 sat"}, {30'd0, sat_c4}, {30'd0, rb[32], ra[32]});
    ra = model(p_ia, 16, 32'h4000_0000);
    rb = model(p_ii, 16, 32'h4000_0000);
    check({nm, " big valid"}, {31'd0, rv_bg}, 32'd1);
    check({nm, " big Ia_pps"}, ia_bg, ra[31:0]);
    check({nm, " big II_pps"}, ii_bg, rb[31:0]);
    check({nm, " big sat"}, {30'd0, sat_bg}, {30'd0, rb[32], ra[32]});
  endtask

  // Runs len cycles from window index 0; upd means the previous window (p_ia/p_ii edges) reports at index 1
  task automatic window(input string nm, input int len, input int ia_n, input int ia_off,
                        input int ii_n, input bit ia_hold, input bit upd,
                        input int p_ia, input int p_ii);
    logic [32:0] r;
    for (int c = 0; c < len; c++) begin
      Ia = ia_hold || ((c >= ia_off) && (c < ia_off + 2 * ia_n) && ((c - ia_off) % 2 == 0));
      II = (c < 2 * ii_n) && (c % 2 == 0);
      tick();
      if (upd && c == 0) begin
        r = model(p_ia, 16, 32'd10);
        e_ia = r[31:0]; e_sat[0] = r[32];
        r = model(p_ii, 16, 32'd10);
        e_ii = r[31:0]; e_sat[1] = r[32];
        check_aux(nm, p_ia, p_ii);
      end
      check_main(nm, c, upd && (c == 0));
    end
  endtask

  task automatic idle_ticks(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_main(nm, i, 1'b0);
    end
  endtask

  initial begin
    reset1 = 1'b1; enable = 1'b0; Ia = 1'b0; II = 1'b0;
    idle_ticks("reset", 3);
    reset1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Ia = i[0]; II = ~i[0];
      tick();
      check_main("idle", i, 1'b0);
    end
    Ia = 1'b0; II = 1'b0;

    // Basic counting over consecutive windows
    enable = 1'b1;
    tick();
    window("w0", 100, 7, 0, 3, 1'b0, 1'b0, 0, 0);
    window("w1", 100, 5, 0, 2, 1'b0, 1'b1, 7, 3);
    check("w1 Ia literal", ia_m, 32'd70);
    check("w1 II literal", ii_m, 32'd30);
    window("w2", 100, 0, 0, 0, 1'b1, 1'b1, 5, 2);
    window("w3", 100, 0, 0, 0, 1'b0, 1'b1, 1, 0);
    check("hold-high literal", ia_m, 32'd10);
    window("w4", 100, 1, 99, 0, 1'b0, 1'b1, 0, 0);
    window("w5", 100, 0, 0, 0, 1'b0, 1'b1, 1, 0);
    check("idx99 literal", ia_m, 32'd10);
    window("w6", 100, 1, 0, 0, 1'b0, 1'b1, 0, 0);
    window("w7", 100, 0, 0, 0, 1'b0, 1'b1, 1, 0);
    check("idx0 literal", ia_m, 32'd10);

    // Counter and product saturation
    window("w8", 100, 20, 0, 0, 1'b0, 1'b1, 0, 0);
    window("w9", 100, 4, 0, 0, 1'b0, 1'b1, 20, 0);
    check("c4 Ia literal", ia_c4, 32'd150);
    check("c4 sat literal", {30'd0, sat_c4}, 32'd1);
    check("main 20 literal", ia_m, 32'd200);

    // Abort at index 50
    window("w10", 50, 10, 0, 0, 1'b0, 1'b1, 4, 0);
    check("big Ia literal", ia_bg, 32'hFFFF_FFFF);
    check("big sat literal", {30'd0, sat_bg}, 32'd1);
    enable = 1'b0;
    idle_ticks("abort50", 5);
    check("abort50 hold literal", ia_m, 32'd40);

    // Line already high when enable rises
    Ia = 1'b1;
    idle_ticks("prehigh", 2);
    enable = 1'b1;
    tick();
    window("w11", 100, 0, 0, 0, 1'b1, 1'b0, 0, 0);
    window("w12", 100, 3, 2, 0, 1'b0, 1'b1, 0, 0);
    check("prehigh literal", ia_m, 32'd0);

    // Abort in the terminal cycle
    window("w13", 99, 2, 0, 0, 1'b0, 1'b1, 3, 0);
    enable = 1'b0;
    idle_ticks("abort99", 4);
    check("abort99 hold literal", ia_m, 32'd30);

    // Reset with an update pending
    enable = 1'b1;
    tick();
    window("w14", 100, 6, 0, 1, 1'b0, 1'b0, 0, 0);
    window("w15", 100, 2, 0, 0, 1'b0, 1'b1, 6, 1);
    reset1 = 1'b1;
    tick();
    e_ia = '0; e_ii = '0; e_sat = '0;
    check_main("rst_mid", 0, 1'b0);
    check("rst_mid c4 Ia", ia_c4, 32'd0);
    check("rst_mid big Ia", ia_bg, 32'd0);
    reset1 = 1'b0; enable = 1'b0;
    idle_ticks("post_rst", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
